// File: rtl/sub_64bit_pipe_pkg.sv
// Shared sizing and the per-stage pipeline record for the pipelined subtractor.
package sub_pkg;

  localparam int WIDTH_DEF  = 64;
  localparam int STAGES_DEF = 4;
  localparam int CHUNK_DEF  = WIDTH_DEF / STAGES_DEF;

  // One pipeline stage. diff_lo collects result chunks shifted in from the top,
  // so after the last stage it holds the full difference. a_hi/b_hi keep the
  // operand bits not yet processed, right-aligned for the next stage.
  typedef struct packed {
    logic                 valid;
    logic                 borrow;
    logic [WIDTH_DEF-1:0] diff_lo;
    logic [WIDTH_DEF-1:0] a_hi;
    logic [WIDTH_DEF-1:0] b_hi;
    logic                 a_msb;
    logic                 b_msb;
  } stage_t;

  // Signed overflow of a - b: the operand signs differ and the result sign
  // does not follow the minuend.
  function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/sub_64bit_pipe_if.sv
// Operand/result handshake bundle for the pipelined subtractor.
interface sub_64bit_pipe_if
  import sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero, ovf
  );

endinterface

// File: rtl/sub_64bit_pipe_chunk.sv
// Combinational ripple-borrow slice: d = x - y - bi, bo = borrow out of the MSB.
module sub_chunk
  import sub_pkg::*;
#(
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             bi,
  output logic [CHUNK-1:0] d,
  output logic             bo
);

  logic [CHUNK:0] brw_s;

  // Ripple the borrow from bit 0 upward through the slice.
  always_comb begin
    brw_s    = '0;
    d        = '0;
    brw_s[0] = bi;
    for (int i = 0; i < CHUNK; i++) begin
      d[i]       = x[i] ^ y[i] ^ brw_s[i];
      brw_s[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & brw_s[i]);
    end
  end

  assign bo = brw_s[CHUNK];

endmodule

// File: rtl/sub_64bit_pipe.sv
// Pipelined subtractor: diff = a - b - bin, one CHUNK-wide slice per stage,
// plus a registered output stage that also derives zero and ovf.
// WIDTH must equal the package record width and be a multiple of STAGES.
module sub_64bit_pipe
  import sub_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STAGES = STAGES_DEF
) (
  input logic             clk,
  input logic             rst_n,
  sub_64bit_pipe_if.slave bus
);

  localparam int CHUNK = WIDTH / STAGES;

  stage_t           st_r  [STAGES];
  stage_t           nxt_s [STAGES];
  logic             adv_s;
  logic             out_valid_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             zero_r;
  logic             ovf_r;

  // The whole pipe moves as one; it only stops when a result is waiting.
  assign adv_s         = !out_valid_r || bus.out_ready;
  assign bus.in_ready  = adv_s;
  assign bus.out_valid = out_valid_r;
  assign bus.diff      = diff_r;
  assign bus.bout      = bout_r;
  assign bus.zero      = zero_r;
  assign bus.ovf       = ovf_r;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           src_s;
    logic [CHUNK-1:0] d_s;
    logic             bo_s;

    if (k == 0) begin : g_src_in
      assign src_s = '{valid:   bus.in_valid,
                       borrow:  bus.bin,
                       diff_lo: {WIDTH{1'b0}},
                       a_hi:    bus.a,
                       b_hi:    bus.b,
                       a_msb:   bus.a[WIDTH-1],
                       b_msb:   bus.b[WIDTH-1]};
    end else begin : g_src_prev
      assign src_s = st_r[k-1];
    end

    sub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .x  (src_s.a_hi[CHUNK-1:0]),
      .y  (src_s.b_hi[CHUNK-1:0]),
      .bi (src_s.borrow),
      .d  (d_s),
      .bo (bo_s)
    );

    assign nxt_s[k] = '{valid:   src_s.valid,
                        borrow:  bo_s,
                        diff_lo: {d_s, src_s.diff_lo[WIDTH-1:CHUNK]},
                        a_hi:    src_s.a_hi >> CHUNK,
                        b_hi:    src_s.b_hi >> CHUNK,
                        a_msb:   src_s.a_msb,
                        b_msb:   src_s.b_msb};
  end

  // Stage registers: shift forward together (bubbles included) when advancing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        st_r[k] <= '0;
      end
    end else if (adv_s) begin
      for (int k = 0; k < STAGES; k++) begin
        st_r[k] <= nxt_s[k];
      end
    end
  end

  // Output register: load a finished result, keep data stable across bubbles and stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      diff_r      <= '0;
      bout_r      <= 1'b0;
      zero_r      <= 1'b0;
      ovf_r       <= 1'b0;
    end else if (adv_s) begin
      out_valid_r <= st_r[STAGES-1].valid;
      if (st_r[STAGES-1].valid) begin
        diff_r <= st_r[STAGES-1].diff_lo;
        bout_r <= st_r[STAGES-1].borrow;
        zero_r <= (st_r[STAGES-1].diff_lo == {WIDTH{1'b0}});
        ovf_r  <= ovf_calc(st_r[STAGES-1].a_msb, st_r[STAGES-1].b_msb,
                           st_r[STAGES-1].diff_lo[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_sub_64bit_pipe.sv
// Self-checking bench for sub_64bit_pipe: vector table, ready-pattern stream,
// and a mid-flight reset, all checked through an in-order scoreboard.
module tb_sub_64bit_pipe;

  typedef struct packed {
    logic [63:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;
  } exp_t;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    exp_t        e;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;
  int   n_out;
  int   rdy_mode;
  int   rdy_cyc;
  int   rdy_pat [4];
  exp_t sb [$];
  vec_t tbl [9];

  sub_64bit_pipe_if #(.WIDTH(64)) bus ();

  sub_64bit_pipe #(.WIDTH(64), .STAGES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic bin);
    logic [64:0] r;
    exp_t        e;
    r      = {1'b0, a} - {1'b0, b} - {64'd0, bin};
    e.diff = r[63:0];
    e.bout = r[64];
    e.zero = (r[63:0] == 64'd0);
    e.ovf  = (a[63] != b[63]) && (r[63] != a[63]);
    return e;
  endfunction

  // out_ready driver: 0 = always ready, 1 = pattern 1,0,0,1, 2 = never ready
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: begin
        bus.out_ready = rdy_pat[rdy_cyc % 4][0];
        rdy_cyc++;
      end
      2:       bus.out_ready = 1'b0;
      default: bus.out_ready = 1'b1;
    endcase
  end

  // Output monitor: handshake rule and scoreboard compare, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready_rule", {63'd0, bus.in_ready}, {63'd0, (!bus.out_valid || bus.out_ready)});
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_result: got diff %h with empty scoreboard", bus.diff);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result_diff", bus.diff, e.diff);
          chk("result_flags", {61'd0, bus.bout, bus.zero, bus.ovf}, {61'd0, e.bout, e.zero, e.ovf});
          n_out++;
        end
      end
    end
  end

  // Present one op and hold it until accepted; called just after a rising edge.
  task automatic drive_op(input logic [63:0] a, input logic [63:0] b, input logic bin, input exp_t e);
    bit done;
    done = 1'b0;
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bin;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: got no accept required accept within 200 cycles");
    end
  endtask

  // Right after an accept into an empty pipe: out_valid low for 4 samples, then high.
  task automatic check_latency(input string name);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk(name, {63'd0, bus.out_valid}, 64'd0);
    end
    @(negedge clk);
    chk(name, {63'd0, bus.out_valid}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int expect_out);
    for (int t = 0; t < 300 && (sb.size() != 0 || bus.out_valid); t++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", {32'd0, sb.size()}, 64'd0);
    chk("result_count", n_out, expect_out);
  endtask

  initial begin
    int   n_exp;
    exp_t e;
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rbin;

    checks  = 0;
    fails   = 0;
    n_out   = 0;
    rdy_mode = 0;
    rdy_cyc = 0;
    rdy_pat = '{1, 0, 0, 1};
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = 64'd0;
    bus.b         = 64'd0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b1;

    tbl[0] = '{64'd21, 64'd20, 1'b0, '{64'd1, 1'b0, 1'b0, 1'b0}};
    tbl[1] = '{64'd200, 64'd8, 1'b1, '{64'd191, 1'b0, 1'b0, 1'b0}};
    tbl[2] = '{64'd5, 64'd5, 1'b0, '{64'd0, 1'b0, 1'b1, 1'b0}};
    tbl[3] = '{64'd0, 64'd92182163, 1'b0, '{64'hFFFF_FFFF_FA81_696D, 1'b1, 1'b0, 1'b0}};
    tbl[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd92182163, 1'b0, '{64'hFFFF_FFFF_FA81_696C, 1'b0, 1'b0, 1'b0}};
    tbl[5] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, '{64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1}};
    tbl[6] = '{64'h0000_0000_0001_0000, 64'd1, 1'b0, '{64'h0000_0000_0000_FFFF, 1'b0, 1'b0, 1'b0}};
    tbl[7] = '{64'd0, 64'd0, 1'b1, '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0}};
    tbl[8] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, '{64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1}};

    // reset state
    #3;
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_diff", bus.diff, 64'd0);
    chk("rst_flags", {61'd0, bus.bout, bus.zero, bus.ovf}, 64'd0);
    #19;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // table vectors, first one also timed against the 4-cycle latency
    drive_op(tbl[0].a, tbl[0].b, tbl[0].bin, tbl[0].e);
    check_latency("latency_first");
    for (int i = 1; i < 9; i++) begin
      drive_op(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].e);
    end
    n_exp = 9;
    drain(n_exp);

    // back-to-back stream with out_ready pattern 1,0,0,1
    rdy_mode = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      ra   = {$urandom, $urandom};
      rb   = (i == 3) ? ra : {$urandom, $urandom};
      rbin = 1'($urandom_range(0, 1));
      if (i == 3) rbin = 1'b0;
      drive_op(ra, rb, rbin, model(ra, rb, rbin));
    end
    n_exp += 8;
    drain(n_exp);

    // reset with three ops in flight
    rdy_mode = 2;
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) begin
      ra = 64'd1000 + 64'(i);
      drive_op(ra, 64'd7, 1'b0, model(ra, 64'd7, 1'b0));
    end
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("stalled_out_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("stalled_in_ready", {63'd0, bus.in_ready}, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    sb.delete();
    rdy_mode = 0;
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_op(64'd50, 64'd60, 1'b1, model(64'd50, 64'd60, 1'b1));
    check_latency("latency_after_rst");
    n_exp += 1;
    drain(n_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
